// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and sizing helpers for the unified memory port arbiter.
// Imported by the arbiter top and its winner-selection sub-block.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_IF = 1'b0,
        ARB_OWN_DM = 1'b1
    } arb_owner_e;

    // Wide enough for MEM_LAT - 1 with MEM_LAT up to 15.
    localparam int LAT_W = 4;

    // Bits needed to hold a saturating count of 0..max.
    function automatic int starve_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Data wins by default; a fetch that has waited STARVE_MAX data grants wins.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int SC_W       = 3
) (
    input  logic            if_req,
    input  logic            dm_req,
    input  logic [SC_W-1:0] starve_cnt,
    output logic            pick_valid,
    output logic            pick_dm
);

    logic fetch_starved;

    always_comb begin
        fetch_starved = (starve_cnt >= SC_W'(STARVE_MAX));
        pick_valid    = if_req | dm_req;
        pick_dm       = dm_req & (~if_req | ~fetch_starved);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency memory port,
// returns read data / store acknowledges and drives the pipeline stall requests.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fe,
    output logic              stall_mem
);

    localparam int SC_W = starve_w(STARVE_MAX);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              we_q, we_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic pick_valid;
    logic pick_dm;
    logic grant;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SC_W       (SC_W)
    ) u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .starve_cnt (starve_cnt_q),
        .pick_valid (pick_valid),
        .pick_dm    (pick_dm)
    );

    // Grants only from IDLE, and never while reset is held, so a request
    // presented during reset is first granted in the cycle after release.
    assign grant = rst & (state_q == ARB_IDLE) & pick_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (grant) state_d = ARB_WAIT;
            ARB_WAIT: if (lat_cnt_q == '0) state_d = ARB_RESP;
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = grant & ~pick_dm;
        dm_gnt    = grant & pick_dm;
        mem_req   = grant;
        mem_we    = grant & pick_dm & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant) begin
            mem_addr = pick_dm ? dm_addr : if_addr;
            if (pick_dm) mem_wdata = dm_wdata;
        end
        if_rvalid = (state_q == ARB_RESP) & (owner_q == ARB_OWN_IF);
        dm_rvalid = (state_q == ARB_RESP) & (owner_q == ARB_OWN_DM);
        stall_fe  = rst & if_req & ~if_rvalid;
        stall_mem = rst & dm_req & ~dm_rvalid;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
    end

    always_comb begin
        owner_d      = owner_q;
        we_d         = we_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if (grant) begin
            owner_d   = pick_dm ? ARB_OWN_DM : ARB_OWN_IF;
            we_d      = pick_dm & dm_we;
            lat_cnt_d = LAT_W'(MEM_LAT - 1);
            // Only data grants that bypass a waiting fetch count toward starvation.
            if (pick_dm && if_req) begin
                if (starve_cnt_q < SC_W'(STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + SC_W'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
        if (state_q == ARB_WAIT) begin
            if (lat_cnt_q != '0) begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end else if (owner_q == ARB_OWN_IF) begin
                if_rdata_d = mem_rdata;
            end else if (!we_q) begin
                dm_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= ARB_OWN_IF;
            we_q         <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            owner_q      <= owner_d;
            we_q         <= we_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_fe, stall_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_fe(stall_fe), .stall_mem(stall_mem)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] init_val(input logic [7:0] idx);
        case (idx)
            8'd2:    return 32'h00A0_0113;
            8'd8:    return 32'h1111_2222;
            8'd16:   return 32'h0050_0093;
            default: return {24'h5A5A5A, idx};
        endcase
    endfunction

    logic [31:0] wr_arr [0:255];
    bit          wr_vld [0:255];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    bit          vld_pipe [0:MEM_LAT-1];

    always @(posedge clk) begin
        vld_pipe[0] <= mem_req && !mem_we;
        rd_pipe[0]  <= wr_vld[mem_addr[9:2]] ? wr_arr[mem_addr[9:2]] : init_val(mem_addr[9:2]);
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            rd_pipe[i]  <= rd_pipe[i-1];
        end
        if (mem_req && mem_we) begin
            wr_arr[mem_addr[9:2]] <= mem_wdata;
            wr_vld[mem_addr[9:2]] <= 1'b1;
        end
    end

    // Read data is only meaningful in the exact cycle; poison it otherwise.
    assign mem_rdata = vld_pipe[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : 32'hBAD0_BAD0;

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          dm;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        int          gap;   // required cycles since previous grant, -1 = any
        int          at;    // required absolute cycle, -1 = any
    } gnt_t;

    gnt_t        exp_gnt [$];
    logic [31:0] exp_if  [$];
    logic [31:0] exp_dm  [$];

    int cyc = 0;
    int to_count = 0;
    bit done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus ----------------
    task automatic dm_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input bit push_gnt, input int gap);
        bit seen;
        if (push_gnt) exp_gnt.push_back('{1'b1, addr, we, wdata, gap, -1});
        exp_dm.push_back(exp_rdata);
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (dm_rvalid) seen = 1'b1;
        end
        if (!seen) to_count++;
        @(posedge clk); #1;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic if_fetch(input logic [31:0] addr, input logic [31:0] exp_rdata,
                            input bit push_gnt);
        bit seen;
        if (push_gnt) exp_gnt.push_back('{1'b0, addr, 1'b0, 32'h0, -1, -1});
        exp_if.push_back(exp_rdata);
        if_req = 1'b1; if_addr = addr;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (if_rvalid) seen = 1'b1;
        end
        if (!seen) to_count++;
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = '0;
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        // Release with a data request already pending: grant in this very cycle.
        rst = 1'b1;
        exp_gnt.push_back('{1'b1, 32'h20, 1'b0, 32'h0, -1, cyc});
        dm_access(1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, -1);

        if_fetch(32'h40, 32'h0050_0093, 1'b1);

        // Store leaves dm_rdata at the previous load value.
        dm_access(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1, -1);
        dm_access(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1, 4);

        // Simultaneous requests with starve_cnt = 0.
        exp_gnt.push_back('{1'b1, 32'h180, 1'b0, 32'h0, -1, -1});
        exp_gnt.push_back('{1'b0, 32'h44, 1'b0, 32'h0, 4, -1});
        fork
            dm_access(1'b0, 32'h180, 32'h0, 32'h5A5A_5A60, 1'b0, -1);
            if_fetch(32'h44, 32'h5A5A_5A11, 1'b0);
        join

        // Both held continuously: D D D D I D D D D I.
        for (int k = 0; k < 4; k++) exp_gnt.push_back('{1'b1, 32'h200 + 4*k, 1'b0, 32'h0, 4, -1});
        exp_gnt.push_back('{1'b0, 32'h300, 1'b0, 32'h0, 4, -1});
        for (int k = 4; k < 8; k++) exp_gnt.push_back('{1'b1, 32'h200 + 4*k, 1'b0, 32'h0, 4, -1});
        exp_gnt.push_back('{1'b0, 32'h304, 1'b0, 32'h0, 4, -1});
        fork
            begin
                for (int k = 0; k < 8; k++)
                    dm_access(1'b0, 32'h200 + 4*k, 32'h0, 32'h5A5A_5A80 + k, 1'b0, -1);
            end
            begin
                for (int j = 0; j < 2; j++)
                    if_fetch(32'h300 + 4*j, 32'h5A5A_5AC0 + j, 1'b0);
            end
        join

        // Reset while a load is in WAIT: its response must never appear.
        exp_gnt.push_back('{1'b1, 32'h100, 1'b0, 32'h0, -1, -1});
        dm_req = 1'b1; dm_addr = 32'h100;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (dm_gnt) seen = 1'b1;
        end
        if (!seen) to_count++;
        @(posedge clk); #1;
        rst = 1'b0;
        dm_req = 1'b0; dm_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        if_fetch(32'h8, 32'h00A0_0113, 1'b1);
        repeat (8) @(posedge clk);
        done = 1'b1;
    end

    // ---------------- monitor ----------------
    int   total = 0;
    int   bad = 0;
    int   to_seen = 0;
    int   last_gnt_cyc = -100;
    int   last_if_gnt_cyc = -100;
    int   last_dm_gnt_cyc = -100;
    gnt_t mon_e;
    logic [31:0] mon_d;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, stall_fe, stall_mem} != 8'h0 ||
                if_rdata != 0 || dm_rdata != 0 || mem_addr != 0 || mem_wdata != 0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d ctl=%b if_rdata=%h dm_rdata=%h mem_addr=%h mem_wdata=%h required all zero",
                         cyc, {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, stall_fe, stall_mem},
                         if_rdata, dm_rdata, mem_addr, mem_wdata);
            end
        end else begin
            total++;
            if (stall_fe !== (if_req && !if_rvalid)) begin
                bad++;
                $display("FAIL stall_fe cyc=%0d got=%b required=%b", cyc, stall_fe, if_req && !if_rvalid);
            end
            total++;
            if (stall_mem !== (dm_req && !dm_rvalid)) begin
                bad++;
                $display("FAIL stall_mem cyc=%0d got=%b required=%b", cyc, stall_mem, dm_req && !dm_rvalid);
            end
            if (if_gnt || dm_gnt) begin
                total++;
                if (exp_gnt.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_gnt cyc=%0d if_gnt=%b dm_gnt=%b required none", cyc, if_gnt, dm_gnt);
                end else begin
                    mon_e = exp_gnt.pop_front();
                    if ((if_gnt && dm_gnt) || dm_gnt != mon_e.dm) begin
                        bad++;
                        $display("FAIL gnt_owner cyc=%0d if_gnt=%b dm_gnt=%b required dm=%b", cyc, if_gnt, dm_gnt, mon_e.dm);
                    end
                    total++;
                    if (!mem_req || mem_addr != mon_e.addr || mem_we != mon_e.we || mem_wdata != mon_e.wdata) begin
                        bad++;
                        $display("FAIL mem_cmd cyc=%0d got req=%b addr=%h we=%b wdata=%h required req=1 addr=%h we=%b wdata=%h",
                                 cyc, mem_req, mem_addr, mem_we, mem_wdata, mon_e.addr, mon_e.we, mon_e.wdata);
                    end
                    if (mon_e.gap >= 0) begin
                        total++;
                        if (cyc - last_gnt_cyc != mon_e.gap) begin
                            bad++;
                            $display("FAIL gnt_gap cyc=%0d got=%0d required=%0d", cyc, cyc - last_gnt_cyc, mon_e.gap);
                        end
                    end
                    if (mon_e.at >= 0) begin
                        total++;
                        if (cyc != mon_e.at) begin
                            bad++;
                            $display("FAIL gnt_cycle got=%0d required=%0d", cyc, mon_e.at);
                        end
                    end
                end
                last_gnt_cyc = cyc;
                if (dm_gnt) last_dm_gnt_cyc = cyc;
                else        last_if_gnt_cyc = cyc;
            end
            if (if_rvalid) begin
                total++;
                if (exp_if.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_if_rvalid cyc=%0d if_rdata=%h", cyc, if_rdata);
                end else begin
                    mon_d = exp_if.pop_front();
                    if (if_rdata != mon_d) begin
                        bad++;
                        $display("FAIL if_rdata cyc=%0d got=%h required=%h", cyc, if_rdata, mon_d);
                    end
                    total++;
                    if (cyc != last_if_gnt_cyc + MEM_LAT + 1) begin
                        bad++;
                        $display("FAIL if_latency got=%0d required=%0d", cyc - last_if_gnt_cyc, MEM_LAT + 1);
                    end
                end
            end
            if (dm_rvalid) begin
                total++;
                if (exp_dm.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_dm_rvalid cyc=%0d dm_rdata=%h", cyc, dm_rdata);
                end else begin
                    mon_d = exp_dm.pop_front();
                    if (dm_rdata != mon_d) begin
                        bad++;
                        $display("FAIL dm_rdata cyc=%0d got=%h required=%h", cyc, dm_rdata, mon_d);
                    end
                    total++;
                    if (cyc != last_dm_gnt_cyc + MEM_LAT + 1) begin
                        bad++;
                        $display("FAIL dm_latency got=%0d required=%0d", cyc - last_dm_gnt_cyc, MEM_LAT + 1);
                    end
                end
            end
            if (if_gnt || dm_gnt || if_rvalid || dm_rvalid)
                $display("cyc=%0d if_gnt=%b dm_gnt=%b if_rvalid=%b dm_rvalid=%b mem_addr=%h if_rdata=%h dm_rdata=%h",
                         cyc, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_addr, if_rdata, dm_rdata);
        end
        if (to_count != to_seen) begin
            bad += to_count - to_seen;
            total += to_count - to_seen;
            $display("FAIL timeout cyc=%0d waits_expired=%0d required=0", cyc, to_count - to_seen);
            to_seen = to_count;
        end
        if (done || cyc > 4000) begin
            total++;
            if (!done || exp_gnt.size() != 0 || exp_if.size() != 0 || exp_dm.size() != 0) begin
                bad++;
                $display("FAIL drain done=%b pending gnt=%0d if=%0d dm=%0d required all 0",
                         done, exp_gnt.size(), exp_if.size(), exp_dm.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters: the Fetch stage (instruction reads) and the Memory stage (data loads/stores).
- Serialises accesses and sequences each one through a fixed-latency memory.
- Returns read data or write acknowledges, and generates the stall requests consumed by the hazard unit.
- Sits between the pipeline stages and the memory macro, one level below the simulator top.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from memory request to valid mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive data grants allowed while a fetch waits

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch read request; held until if_rvalid
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  if_rdata valid (1-cycle pulse)
if_rdata  out  DATA_W  instruction word
dm_req  in  1  data request; held until dm_rvalid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data request accepted (1-cycle pulse)
dm_rvalid  out  1  load data valid or store done (1-cycle pulse)
dm_rdata  out  DATA_W  load data
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_req
stall_fe  out  1  if_req & ~if_rvalid
stall_mem  out  1  dm_req & ~dm_rvalid

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; lat_cnt, starve_cnt, owner cleared.
  - All outputs 0, including rdata registers.
  - Any in-flight access is discarded; mem_rdata for it is ignored after release.
- FSM states: IDLE, WAIT, RESP. One transaction in flight at a time.
- IDLE:
  - If dm_req and (!if_req or starve_cnt < STARVE_MAX): grant data.
  - Else if if_req: grant fetch.
  - Else stay in IDLE.
  - Grant cycle T (combinational, same cycle):
    - gnt pulse to the winner.
    - mem_req = 1; mem_addr and mem_we from the winner (mem_we = 0 for fetch); mem_wdata = dm_wdata for data, 0 otherwise.
    - owner <= winner; lat_cnt <= MEM_LAT - 1; go to WAIT.
- WAIT:
  - mem_req = 0; lat_cnt decrements.
  - When lat_cnt == 0 (cycle T+MEM_LAT): capture mem_rdata into the owner's rdata register (loads and fetches only; a store leaves dm_rdata unchanged); go to RESP.
- RESP (cycle T+MEM_LAT+1):
  - Owner's rvalid = 1 for exactly one cycle; next state IDLE.
  - No grant is issued in RESP, so a requester still holding req this cycle is never regranted.
- Requester contract:
  - req, addr, we and wdata stay stable from request until the rvalid cycle inclusive.
  - req may be deasserted or re-presented with a new address from the next cycle.
  - Arbiter behaviour under protocol violation is undefined; the bench asserts against it.
- Latency and throughput: request to rvalid = MEM_LAT+1 cycles; maximum throughput is one access per MEM_LAT+2 cycles.
- Starvation counter (starve_cnt):
  - Data grant with if_req = 1: increment, saturating at STARVE_MAX.
  - Fetch grant: clear to 0.
  - Data grant with if_req = 0: clear to 0.
- Simultaneous requests:
  - Data wins by default (older instruction in the pipeline).
  - Fetch wins when starve_cnt == STARVE_MAX.
- Stall outputs:
  - Combinational; high from request until the rvalid cycle, low in the rvalid cycle.
  - No stall when the corresponding req is low.
- rdata registers hold their value between transactions.

Decomposition:
- Constants.v gains the state encodings (ARB_IDLE, ARB_WAIT, ARB_RESP) and the owner encodings (ARB_OWN_IF, ARB_OWN_DM).
- One sub-module, mem_arb_pick: combinational winner selection from if_req, dm_req and starve_cnt.
- FSM, counters and data capture stay in mem_port_arbiter.

Test Plan:
- Reset with dm_req = 1 held, then release → no dm_gnt while rst = 0; all outputs 0; first dm_gnt in the first cycle after release.
- Lone fetch, if_addr = 0x40, memory word 0x00500093, MEM_LAT = 2 → if_gnt at T, mem_addr = 0x40 and mem_we = 0 at T, if_rvalid with if_rdata = 0x00500093 at T+3, stall_fe high T..T+2.
- Store then load to 0x100, wdata = 0xDEADBEEF → mem_we = 1 on the first grant; dm_rvalid at T+3 with dm_rdata unchanged; second grant at T+4; dm_rvalid at T+7 with dm_rdata = 0xDEADBEEF.
- if_req and dm_req held continuously, STARVE_MAX = 4 → grant order D, D, D, D, I, D, D, D, D, I; never 5 consecutive data grants.
- Simultaneous if_req and dm_req with starve_cnt = 0 → dm_gnt; if_gnt only at the IDLE following dm_rvalid (T+4).
- Assert rst = 0 during WAIT of a load → immediate IDLE with outputs 0; after release, a new fetch to 0x8 completes correctly and no stale dm_rvalid appears.
